// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and default constants for the PC generator
//
// Purpose: FSM state encoding and default widths/values used by pc_gen and pc_ras.
// Contents: pc_state_t (S_BOOT, S_RUN), CPU_RESET_ADDR, INST_ADDR_W, HOLD_FLAG_W,
//           HOLD_PC_LVL, INST_STEP_BYTES, RAS_DEPTH_DEF.
package pc_gen_pkg;

    localparam int          INST_ADDR_W     = 32;
    localparam logic [31:0] CPU_RESET_ADDR  = 32'h0000_0000;
    localparam int          INST_STEP_BYTES = 4;
    localparam int          HOLD_FLAG_W     = 3;
    localparam logic [2:0]  HOLD_PC_LVL     = 3'b001;
    localparam int          RAS_DEPTH_DEF   = 4;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack for call/return prediction
//
// Purpose: stack of return addresses; a push when full overwrites the oldest entry,
//          a pop when empty is ignored, push+pop together replaces the top entry.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   clr            synchronous clear (debug reset)
//   push, pop      stack operations (already qualified by the caller)
//   push_addr      address written on push
//   top_addr       current top entry (meaningful only when count != 0)
//   count          number of valid entries, 0..DEPTH
module pc_ras #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    output logic [ADDR_W-1:0]          top_addr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top;
    logic              empty;
    logic              full;
    logic              swap;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    // Push and pop together on a non-empty stack replace the top in place.
    assign swap     = push && pop && !empty;
    assign wr_en    = push;
    assign wr_idx   = swap ? top : top + 1'b1;
    assign top_addr = mem[top];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            top   <= '0;
            count <= '0;
        end else if (swap) begin
            top   <= top;
        end else if (push) begin
            // Pointer wraps, so a full-stack push silently drops the oldest entry.
            top <= top + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            top   <= top - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with redirect arbitration and RAS
//
// Purpose: produces the fetch address on a valid/ready handshake, arbitrating
//          trap > jump > hold > predicted return > sequential increment.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   jtag_reset_flag_i  debug reset, same effect as rstn
//   trap_flag_i/trap_addr_i, jump_flag_i/jump_addr_i   redirect requests
//   hold_flag_i        pipeline hold level; >= HOLD_PC freezes the PC
//   pred_call_i/pred_push_addr_i, pred_ret_i           decode RAS predictions
//   pc_ready_i         fetch interface accepts pc_o
//   pc_o, pc_valid_o   fetch request
//   redirect_o         pc_o was loaded non-sequentially on the last edge
//   ras_count_o        valid RAS entries
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CPU_RESET_ADDR),
    parameter int                INST_STEP  = INST_STEP_BYTES,
    parameter int                HOLD_W     = HOLD_FLAG_W,
    parameter logic [HOLD_W-1:0] HOLD_PC    = HOLD_W'(HOLD_PC_LVL),
    parameter int                RAS_DEPTH  = RAS_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       jtag_reset_flag_i,
    input  logic                       trap_flag_i,
    input  logic [ADDR_W-1:0]          trap_addr_i,
    input  logic                       jump_flag_i,
    input  logic [ADDR_W-1:0]          jump_addr_i,
    input  logic [HOLD_W-1:0]          hold_flag_i,
    input  logic                       pred_call_i,
    input  logic [ADDR_W-1:0]          pred_push_addr_i,
    input  logic                       pred_ret_i,
    input  logic                       pc_ready_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       pc_valid_o,
    output logic                       redirect_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_STEP);

    pc_state_t         state;
    logic              ras_en;
    logic              ras_push;
    logic              ras_pop;
    logic              ret_taken;
    logic [ADDR_W-1:0] ras_top;

    assign pc_valid_o = (state == S_RUN) && (hold_flag_i < HOLD_PC);

    // Predictions are squashed by any higher-priority redirect, a hold, or boot.
    assign ras_en    = pc_valid_o && !trap_flag_i && !jump_flag_i;
    assign ras_push  = ras_en && pred_call_i;
    assign ras_pop   = ras_en && pred_ret_i;
    assign ret_taken = ras_pop && (ras_count_o != '0);

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (jtag_reset_flag_i),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (pred_push_addr_i),
        .top_addr  (ras_top),
        .count     (ras_count_o)
    );

    always_ff @(posedge clk) begin
        if (!rstn || jtag_reset_flag_i) begin
            state      <= S_BOOT;
            pc_o       <= RESET_ADDR;
            redirect_o <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            case (state)
                S_BOOT: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    // Trap/jump override hold and a stalled handshake; the
                    // un-accepted address is simply replaced.
                    if (trap_flag_i) begin
                        pc_o       <= trap_addr_i;
                        redirect_o <= 1'b1;
                    end else if (jump_flag_i) begin
                        pc_o       <= jump_addr_i;
                        redirect_o <= 1'b1;
                    end else if (hold_flag_i >= HOLD_PC) begin
                        pc_o <= pc_o;
                    end else if (ret_taken) begin
                        pc_o       <= ras_top;
                        redirect_o <= 1'b1;
                    end else if (pc_ready_i) begin
                        pc_o <= pc_o + STEP;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking testbench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rstn, jtag, trap, jump, call, ret, ready;
    logic [31:0] trap_addr, jump_addr, push_addr;
    logic [2:0]  hold;
    logic [31:0] pc;
    logic        pc_valid, redirect;
    logic [2:0]  ras_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_red;
    logic [31:0] ras_q[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .clk               (clk),
        .rstn              (rstn),
        .jtag_reset_flag_i (jtag),
        .trap_flag_i       (trap),
        .trap_addr_i       (trap_addr),
        .jump_flag_i       (jump),
        .jump_addr_i       (jump_addr),
        .hold_flag_i       (hold),
        .pred_call_i       (call),
        .pred_push_addr_i  (push_addr),
        .pred_ret_i        (ret),
        .pc_ready_i        (ready),
        .pc_o              (pc),
        .pc_valid_o        (pc_valid),
        .redirect_o        (redirect),
        .ras_count_o       (ras_count)
    );

    task automatic model_update();
        if (!rstn || jtag) begin
            m_pc = 32'h0; m_boot = 1; m_red = 0; ras_q.delete();
            return;
        end
        if (m_boot) begin
            m_boot = 0; m_red = 0;
            return;
        end
        m_red = 0;
        if (trap) begin
            m_pc = trap_addr; m_red = 1;
        end else if (jump) begin
            m_pc = jump_addr; m_red = 1;
        end else if (hold == 3'd0) begin
            if (ret && ras_q.size() > 0) begin
                m_pc  = ras_q[ras_q.size()-1];
                m_red = 1;
                if (call) ras_q[ras_q.size()-1] = push_addr;
                else void'(ras_q.pop_back());
            end else begin
                if (call) begin
                    ras_q.push_back(push_addr);
                    if (ras_q.size() > 4) void'(ras_q.pop_front());
                end
                if (ready) m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jtag = 0; trap = 0; jump = 0; call = 0; ret = 0; ready = 1;
        hold = 3'd0; trap_addr = '0; jump_addr = '0; push_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 0;
        step(); step();
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        vectors++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pc_valid); end
        vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", redirect); end
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ras_count); end
        rstn = 1;
        #1;
        vectors++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b want 0", pc_valid); end
        step();
        vectors++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL run_first got pc=%h v=%b want pc=0 v=1", pc, pc_valid); end
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (pc !== 32'(4*i) || redirect !== 1'b0) begin
                errors++; $display("FAIL seq_pc[%0d] got pc=%h red=%b want pc=%h red=0", i, pc, redirect, 32'(4*i));
            end
        end
    endtask

    task automatic test_ready_stall();
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (pc !== 32'h10 || pc_valid !== 1'b1) begin
                errors++; $display("FAIL stall[%0d] got pc=%h v=%b want pc=10 v=1", i, pc, pc_valid);
            end
        end
        ready = 1;
        step();
        vectors++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_release got %h want 14", pc); end
    endtask

    task automatic test_redirect();
        hold = 3'b010; jump = 1; jump_addr = 32'h200;
        step();
        vectors++; if (pc !== 32'h200 || redirect !== 1'b1) begin errors++; $display("FAIL jump_held got pc=%h red=%b want 200/1", pc, redirect); end
        vectors++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL held_valid got %b want 0", pc_valid); end
        trap = 1; trap_addr = 32'h80;
        step();
        vectors++; if (pc !== 32'h80 || redirect !== 1'b1) begin errors++; $display("FAIL trap_prio got pc=%h red=%b want 80/1", pc, redirect); end
        idle_inputs();
        step();
        vectors++; if (pc !== 32'h84 || redirect !== 1'b0) begin errors++; $display("FAIL after_trap got pc=%h red=%b want 84/0", pc, redirect); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] prev;
        for (int i = 0; i < 5; i++) begin
            call = 1; push_addr = 32'h100 + 32'(4*i);
            step();
            vectors++;
            if (ras_count !== 3'((i + 1 > 4) ? 4 : i + 1)) begin
                errors++; $display("FAIL push_count[%0d] got %0d want %0d", i, ras_count, (i + 1 > 4) ? 4 : i + 1);
            end
        end
        call = 0; ret = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (pc !== 32'h114 - 32'(4*k) || redirect !== 1'b1 || ras_count !== 3'(4 - k)) begin
                errors++; $display("FAIL pop[%0d] got pc=%h red=%b cnt=%0d want pc=%h red=1 cnt=%0d",
                                   k, pc, redirect, ras_count, 32'h114 - 32'(4*k), 4 - k);
            end
        end
        prev = pc;
        step();
        vectors++;
        if (pc !== prev + 32'd4 || redirect !== 1'b0 || ras_count !== 3'd0) begin
            errors++; $display("FAIL empty_pop got pc=%h red=%b cnt=%0d want pc=%h red=0 cnt=0", pc, redirect, ras_count, prev + 32'd4);
        end
        ret = 0;
    endtask

    task automatic test_push_pop();
        call = 1; push_addr = 32'h40;
        step();
        push_addr = 32'h50; ret = 1;
        step();
        vectors++;
        if (pc !== 32'h40 || redirect !== 1'b1 || ras_count !== 3'd1) begin
            errors++; $display("FAIL swap got pc=%h red=%b cnt=%0d want 40/1/1", pc, redirect, ras_count);
        end
        call = 0;
        step();
        vectors++;
        if (pc !== 32'h50 || ras_count !== 3'd0) begin
            errors++; $display("FAIL swap_pop got pc=%h cnt=%0d want 50/0", pc, ras_count);
        end
        ret = 0;
    endtask

    task automatic test_wrap();
        jump = 1; jump_addr = 32'hFFFF_FFFC;
        step();
        jump = 0;
        step();
        vectors++;
        if (pc !== 32'h0 || redirect !== 1'b0) begin
            errors++; $display("FAIL wrap got pc=%h red=%b want 0/0", pc, redirect);
        end
    endtask

    task automatic test_jtag();
        for (int i = 0; i < 3; i++) begin
            call = 1; push_addr = 32'h300 + 32'(i);
            step();
        end
        call = 0;
        vectors++; if (ras_count !== 3'd3) begin errors++; $display("FAIL jtag_pre_count got %0d want 3", ras_count); end
        jtag = 1;
        step();
        vectors++;
        if (pc !== 32'h0 || ras_count !== 3'd0 || pc_valid !== 1'b0 || redirect !== 1'b0) begin
            errors++; $display("FAIL jtag_reset got pc=%h cnt=%0d v=%b red=%b want 0/0/0/0", pc, ras_count, pc_valid, redirect);
        end
        jtag = 0;
        #1;
        vectors++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL jtag_boot got v=%b want 0", pc_valid); end
        step();
        vectors++;
        if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL jtag_run got pc=%h v=%b want 0/1", pc, pc_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            jtag      = ($urandom_range(0, 299) == 0);
            trap      = ($urandom_range(0, 19) == 0);
            jump      = ($urandom_range(0, 11) == 0);
            hold      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            call      = ($urandom_range(0, 3) == 0);
            ret       = ($urandom_range(0, 3) == 0);
            ready     = ($urandom_range(0, 3) != 0);
            trap_addr = $urandom;
            jump_addr = $urandom;
            push_addr = $urandom;
            step();
            vectors++;
            if (pc !== m_pc || redirect !== m_red || ras_count !== 3'(ras_q.size()) ||
                pc_valid !== (!m_boot && hold == 3'd0)) begin
                errors++;
                $display("FAIL random[%0d] got pc=%h red=%b cnt=%0d v=%b want pc=%h red=%b cnt=%0d v=%b",
                         n, pc, redirect, ras_count, pc_valid, m_pc, m_red, ras_q.size(), !m_boot && hold == 3'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_stall();
        test_redirect();
        test_ras_overflow();
        test_push_pop();
        test_wrap();
        test_jtag();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
